// File: rtl/serial_bit_feeder_pkg.sv
// serial_bit_feeder_pkg: gray-coded FSM states and defaults shared with the detector family
package serial_bit_feeder_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_PAR   = 2'b11
    } state_t;
    localparam logic IDLE_LEVEL_DEF = 1'b0;
endpackage

// File: rtl/serial_bit_feeder_if.sv
// serial_bit_feeder_if: parallel word valid/ready handshake into the feeder
interface serial_bit_feeder_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] par_in;
    logic             par_valid;
    logic             par_ready;
    modport master (output par_in, par_valid, input par_ready);
    modport slave  (input par_in, par_valid, output par_ready);
endinterface

// File: rtl/serial_bit_feeder_ser_shift_reg.sv
// ser_shift_reg: loadable shift register with elaboration-time direction and serial out
module ser_shift_reg #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] d,
    output logic             q_out
);
    logic [WIDTH-1:0] q;
    // load wins over shift; the bit on q_out is the one currently being sent
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else      q <= load ? d : shift_en ? ((MSB_FIRST != 0) ? q << 1 : q >> 1) : q;
    end
    assign q_out = (MSB_FIRST != 0) ? q[WIDTH-1] : q[0];
endmodule

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-to-serial front end; define SER_PARITY_EN to append an even-parity bit
module serial_bit_feeder
    import serial_bit_feeder_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
    input  logic                clk,
    input  logic                rst,
    serial_bit_feeder_if.slave  par,
    output logic                d_out,
    output logic                bit_valid,
    output logic                frame_start,
    output logic                busy
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic          last, ready, accept, load, shift_en, sr_out;
    assign last   = state == ST_SHIFT && cnt == LAST;
`ifdef SER_PARITY_EN
    logic par_bit;
    assign ready  = state == ST_IDLE || state == ST_PAR;
`else
    assign ready  = state == ST_IDLE || last;
`endif
    assign accept        = par.par_valid && ready;
    assign par.par_ready = ready;
    ser_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (shift_en),
        .d        (par.par_in),
        .q_out    (sr_out)
    );
    // state register; unused code 2'b10 falls back to IDLE via the next-state default
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_n;
    end
    // next state plus shift-register load/shift strobes; reloading on the last bit keeps frames gapless
    always_comb begin
        state_n  = ST_IDLE;
        load     = 1'b0;
        shift_en = 1'b0;
        case (state)
            ST_IDLE: begin
                state_n = accept ? ST_SHIFT : ST_IDLE;
                load    = accept;
            end
            ST_SHIFT: begin
                if (!last) begin
                    state_n  = ST_SHIFT;
                    shift_en = 1'b1;
                end else begin
`ifdef SER_PARITY_EN
                    state_n = ST_PAR;
`else
                    state_n = accept ? ST_SHIFT : ST_IDLE;
                    load    = accept;
`endif
                end
            end
`ifdef SER_PARITY_EN
            ST_PAR: begin
                state_n = accept ? ST_SHIFT : ST_IDLE;
                load    = accept;
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end
    // bit counter restarts on every load and parks at 0 when the stream goes idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else      cnt <= (load || state_n == ST_IDLE) ? '0 : shift_en ? cnt + CW'(1) : cnt;
    end
`ifdef SER_PARITY_EN
    // even parity of the word is captured alongside it so par_in is free after accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) par_bit <= 1'b0;
        else      par_bit <= load ? ^par.par_in : par_bit;
    end
    assign bit_valid = state == ST_SHIFT || state == ST_PAR;
    assign d_out     = state == ST_SHIFT ? sr_out : state == ST_PAR ? par_bit : IDLE_LEVEL;
`else
    assign bit_valid = state == ST_SHIFT;
    assign d_out     = state == ST_SHIFT ? sr_out : IDLE_LEVEL;
`endif
    assign frame_start = state == ST_SHIFT && cnt == '0;
    assign busy        = bit_valid;
endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: scoreboard bench for serial_bit_feeder (MSB-first and LSB-first instances)
module tb_serial_bit_feeder;
`ifdef SER_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif
    typedef struct packed {logic d; logic fs;} exp_t;
    logic clk = 1'b0;
    logic rst;
    logic a_d, a_bv, a_fs, a_busy, b_d, b_bv, b_fs, b_busy;
    int   pass_cnt = 0;
    int   total = 0;
    int   run_a = 0;
    int   max_run_a = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    serial_bit_feeder_if #(.WIDTH(8)) ia ();
    serial_bit_feeder_if #(.WIDTH(8)) ib ();
    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .rst(rst), .par(ia), .d_out(a_d), .bit_valid(a_bv), .frame_start(a_fs), .busy(a_busy));
    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_b (
        .clk(clk), .rst(rst), .par(ib), .d_out(b_d), .bit_valid(b_bv), .frame_start(b_fs), .busy(b_busy));
    always #5 clk = ~clk;
    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask
    task automatic exp_a(input logic [7:0] w);
        for (int i = 0; i < 8; i++) q_a.push_back(exp_t'{w[7-i], i == 0});
`ifdef SER_PARITY_EN
        q_a.push_back(exp_t'{^w, 1'b0});
`endif
    endtask
    task automatic exp_b(input logic [7:0] w);
        for (int i = 0; i < 8; i++) q_b.push_back(exp_t'{w[i], i == 0});
`ifdef SER_PARITY_EN
        q_b.push_back(exp_t'{^w, 1'b0});
`endif
    endtask
    task automatic put_a(input logic [7:0] w);
        int n = 0;
        exp_a(w);
        ia.par_in = w;
        ia.par_valid = 1'b1;
        while (!ia.par_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_a", ia.par_ready, 1'b1);
        @(posedge clk); #1;
        ia.par_valid = 1'b0;
        ia.par_in = 8'($urandom);
    endtask
    task automatic put_b(input logic [7:0] w);
        int n = 0;
        exp_b(w);
        ib.par_in = w;
        ib.par_valid = 1'b1;
        while (!ib.par_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_b", ib.par_ready, 1'b1);
        @(posedge clk); #1;
        ib.par_valid = 1'b0;
        ib.par_in = 8'($urandom);
    endtask
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst) begin
            check("busy_a", a_busy, a_bv);
            if (a_bv) begin
                run_a++;
                if (run_a > max_run_a) max_run_a = run_a;
                if (q_a.size() == 0) check("extra_bit_a", a_bv, 1'b0);
                else begin
                    e = q_a.pop_front();
                    check("d_a", a_d, e.d);
                    check("fs_a", a_fs, e.fs);
                end
            end else begin
                run_a = 0;
                check("idle_a", a_d, 1'b0);
                check("fs_idle_a", a_fs, 1'b0);
            end
        end
    end
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst) begin
            check("busy_b", b_busy, b_bv);
            if (b_bv) begin
                if (q_b.size() == 0) check("extra_bit_b", b_bv, 1'b0);
                else begin
                    e = q_b.pop_front();
                    check("d_b", b_d, e.d);
                    check("fs_b", b_fs, e.fs);
                end
            end else check("idle_b", b_d, 1'b0);
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end
    initial begin
        rst = 1'b0;
        ia.par_valid = 1'b1;
        ia.par_in = 8'($urandom);
        ib.par_valid = 1'b0;
        ib.par_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_d", a_d, 1'b0);
        check("rst_bv", a_bv, 1'b0);
        check("rst_busy", a_busy, 1'b0);
        check("rst_fs", a_fs, 1'b0);
        check("rst_ready", ia.par_ready, 1'b1);
        ia.par_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("no_accept_in_reset", a_bv, 1'b0);
        put_a(8'hA5);
        for (int i = 1; i <= FRAME; i++) begin
            check("ready_cycle", ia.par_ready, i == FRAME);
            @(posedge clk); #1;
        end
        check("bv_after_frame", a_bv, 1'b0);
        max_run_a = 0;
        put_a(8'hA5);
        put_a(8'h3C);
        repeat (FRAME + 2) @(posedge clk);
        #1;
        check("b2b_run", max_run_a, 2 * FRAME);
        put_b(8'h01);
        repeat (FRAME + 2) @(posedge clk);
        #1;
        put_a(8'hFF);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        q_a.delete();
        #1;
        check("abort_d", a_d, 1'b0);
        check("abort_bv", a_bv, 1'b0);
        check("abort_busy", a_busy, 1'b0);
        check("abort_fs", a_fs, 1'b0);
        check("abort_ready", ia.par_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        put_a(8'h80);
        repeat (FRAME + 2) @(posedge clk);
        #1;
        put_a(8'h07);
        exp_a(8'h81);
        ia.par_in = 8'h81;
        ia.par_valid = 1'b1;
        for (int i = 1; i <= FRAME; i++) begin
            check("tail_ready", ia.par_ready, i == FRAME);
            @(posedge clk); #1;
        end
        ia.par_valid = 1'b0;
        check("next_fs", a_fs, 1'b1);
        repeat (FRAME + 4) @(posedge clk);
        #1;
        check("q_a_drained", q_a.size(), 0);
        check("q_b_drained", q_b.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
